// File: rtl/alu_sequencer.sv
// Control-side sequencer for a combinational ALU: accepts one instruction, reads operands, captures and writes back the result.
// Result appears three cycles after acceptance and is held in WB while result_ready is low; no new instruction is taken until then.
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [19:0]       instr,
    output logic [DATA_W-1:0] alu_in0,
    output logic [DATA_W-1:0] alu_in1,
    output logic [3:0]        alu_select,
    output logic [1:0]        alu_rotate,
    input  logic [DATA_W-1:0] alu_out,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DATA_W-1:0] result_data,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [19:0]       instr_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0] f_select;
    logic [1:0] f_rotate;
    logic [1:0] f_rd;
    logic [1:0] f_rs;
    logic       f_use_imm;
    logic       f_wb_en;
    logic [7:0] f_imm;

    assign f_select  = instr_q[19:16];
    assign f_rotate  = instr_q[15:14];
    assign f_rd      = instr_q[13:12];
    assign f_rs      = instr_q[11:10];
    assign f_use_imm = instr_q[9];
    assign f_wb_en   = instr_q[8];
    assign f_imm     = instr_q[7:0];

    assign instr_ready  = (state == IDLE) && !rst;
    assign result_valid = (state == WB);
    assign dbg_data     = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (instr_valid) state_next = OPER;
            OPER:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU operand registers are only loaded in OPER, so they stay put through EXEC, WB and idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q     <= '0;
            alu_in0     <= '0;
            alu_in1     <= '0;
            alu_select  <= '0;
            alu_rotate  <= '0;
            result_data <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                OPER: begin
                    alu_in0    <= regs[f_rd];
                    alu_in1    <= f_use_imm ? DATA_W'(f_imm) : regs[f_rs];
                    alu_select <= f_select;
                    alu_rotate <= f_rotate;
                end
                EXEC: begin
                    result_data <= alu_out;
                end
                WB: begin
                    if (result_ready && f_wb_en) regs[f_rd] <= result_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus randomized instructions against an architectural register model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [19:0] instr;
    logic [7:0]  alu_in0;
    logic [7:0]  alu_in1;
    logic [3:0]  alu_select;
    logic [1:0]  alu_rotate;
    logic [7:0]  alu_out;
    logic        result_valid;
    logic        result_ready;
    logic [7:0]  result_data;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] m_regs [4];

    alu_sequencer #(.DATA_W(8), .NREGS(4)) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .alu_in0(alu_in0),
        .alu_in1(alu_in1),
        .alu_select(alu_select),
        .alu_rotate(alu_rotate),
        .alu_out(alu_out),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data(result_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = 8'h00;
        if (alu_select == 4'd0) alu_out = alu_in0 + alu_in1;
        else if (alu_select == 4'd1) alu_out = alu_in0 ^ alu_in1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] mk(input logic [3:0] s, input logic [1:0] ro,
                                       input logic [1:0] rd, input logic [1:0] rs,
                                       input logic ui, input logic wb, input logic [7:0] im);
        return {s, ro, rd, rs, ui, wb, im};
    endfunction

    // Issues one instruction, follows it to writeback and checks every visible step.
    task automatic run(input logic [19:0] ins, input int stall, input bit keep_valid, output int waited);
        logic [1:0] rd;
        logic [1:0] rs;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        rd = ins[13:12];
        rs = ins[11:10];
        instr = ins;
        instr_valid = 1'b1;
        dbg_addr = rd;
        waited = 0;
        while (!instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!instr_ready) begin
            check("accept_timeout", {31'd0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        a = m_regs[rd];
        b = ins[9] ? ins[7:0] : m_regs[rs];
        if (ins[19:16] == 4'd0) r = 8'((int'(a) + int'(b)) % 256);
        else r = a ^ b;

        tick();
        if (!keep_valid) instr_valid = 1'b0;
        check("oper_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("oper_result_valid", {31'd0, result_valid}, 32'd0);

        tick();
        check("exec_in0", {24'd0, alu_in0}, {24'd0, a});
        check("exec_in1", {24'd0, alu_in1}, {24'd0, b});
        check("exec_select", {28'd0, alu_select}, {28'd0, ins[19:16]});
        check("exec_rotate", {30'd0, alu_rotate}, {30'd0, ins[15:14]});
        check("exec_result_valid", {31'd0, result_valid}, 32'd0);

        tick();
        check("wb_result_valid", {31'd0, result_valid}, 32'd1);
        check("wb_result_data", {24'd0, result_data}, {24'd0, r});
        check("wb_in0_held", {24'd0, alu_in0}, {24'd0, a});
        check("wb_in1_held", {24'd0, alu_in1}, {24'd0, b});

        for (int k = 0; k < stall; k++) begin
            tick();
            check("stall_result_valid", {31'd0, result_valid}, 32'd1);
            check("stall_instr_ready", {31'd0, instr_ready}, 32'd0);
            check("stall_result_data", {24'd0, result_data}, {24'd0, r});
            check("stall_rotate_held", {30'd0, alu_rotate}, {30'd0, ins[15:14]});
            check("stall_reg_unchanged", {24'd0, dbg_data}, {24'd0, m_regs[rd]});
        end

        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        if (ins[8]) m_regs[rd] = r;
        check("post_result_valid", {31'd0, result_valid}, 32'd0);
        check("post_instr_ready", {31'd0, instr_ready}, 32'd1);
        check("post_dbg_data", {24'd0, dbg_data}, {24'd0, m_regs[rd]});
        check("post_in0_held", {24'd0, alu_in0}, {24'd0, a});
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check(tag, {24'd0, dbg_data}, {24'd0, m_regs[i]});
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        result_ready = 1'b0;
        dbg_addr = '0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        tick();
        tick();
        check("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_in0", {24'd0, alu_in0}, 32'd0);
        check("rst_in1", {24'd0, alu_in1}, 32'd0);
        check("rst_select", {28'd0, alu_select}, 32'd0);
        check("rst_rotate", {30'd0, alu_rotate}, 32'd0);
        check("rst_result_data", {24'd0, result_data}, 32'd0);
        check_all_regs("rst_regs");
        rst = 1'b0;
        tick();
        check("rst_release_ready", {31'd0, instr_ready}, 32'd1);

        // immediate load into reg1
        run(mk(4'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 8'h05), 0, 1'b0, w);
        check("load_reg1", {24'd0, dbg_data}, 32'h05);

        // reg1 = 0xF0, reg2 = 0x20, then reg1 += reg2 with wrap under backpressure
        run(mk(4'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b1, 8'hEB), 0, 1'b0, w);
        run(mk(4'd0, 2'd0, 2'd2, 2'd0, 1'b1, 1'b1, 8'h20), 1, 1'b0, w);
        run(mk(4'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b1, 8'h00), 5, 1'b0, w);
        dbg_addr = 2'd1;
        #1;
        check("wrap_add_reg1", {24'd0, dbg_data}, 32'h10);

        // back-to-back dependent instructions with instr_valid held high
        run(mk(4'd0, 2'd0, 2'd3, 2'd1, 1'b0, 1'b1, 8'h00), 0, 1'b1, w);
        run(mk(4'd1, 2'd0, 2'd3, 2'd0, 1'b1, 1'b1, 8'hFF), 0, 1'b1, w);
        check("b2b_accept_wait", w, 32'd0);
        instr_valid = 1'b0;
        dbg_addr = 2'd3;
        #1;
        check("b2b_reg3", {24'd0, dbg_data}, 32'hEF);

        // rd == rs, rotate pass-through, no writeback
        run(mk(4'd1, 2'd3, 2'd2, 2'd2, 1'b0, 1'b0, 8'h00), 2, 1'b0, w);
        check_all_regs("nowb_regs");

        for (int n = 0; n < 40; n++) begin
            run(mk(4'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 8'($urandom)),
                int'($urandom_range(0, 3)), 1'($urandom), w);
        end
        instr_valid = 1'b0;
        check_all_regs("rand_regs");

        // reset while in EXEC abandons the operation
        instr = mk(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'h77);
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 20) begin
            tick();
            w++;
        end
        check("rexec_accept", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rexec_ready_in_rst", {31'd0, instr_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        check("rexec_ready_after", {31'd0, instr_ready}, 32'd1);
        check("rexec_result_data", {24'd0, result_data}, 32'd0);
        check("rexec_in1", {24'd0, alu_in1}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("rexec_valid_low", {31'd0, result_valid}, 32'd0);
            tick();
        end
        check_all_regs("rexec_regs");

        run(mk(4'd0, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1, 8'h3C), 1, 1'b0, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
